memory_stage: RTL

- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM latch and writeback, and owns the MEM/WB pipeline register.
- For loads and stores it issues a request/handshake transaction on the data-SRAM bus.
- Aligns and extends load data, and generates byte-lane write enables for LWL/LWR.
- Stalls upstream while a memory access is outstanding. Non-memory instructions pass through with 1-cycle latency.

---
 rtl/memory_stage_if.sv | 21 ++
 rtl/memory_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// Data-SRAM request/handshake bus between the MEM stage (master) and the data memory (slave).
interface memory_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// MIPS MEM stage: issues data-SRAM transactions for loads/stores, aligns load data,
// and owns the MEM/WB pipeline register.
module memory_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_EX_MEM,
  input  logic                  MemRead_EX_MEM,
  input  logic                  MemWrite_EX_MEM,
  input  logic [2:0]            LoadType_EX_MEM,
  input  logic [1:0]            StoreSize_EX_MEM,
  input  logic                  MemToReg_EX_MEM,
  input  logic [3:0]            RegWrite_EX_MEM,
  input  logic [1:0]            MFHL_EX_MEM,
  input  logic [4:0]            RegWaddr_EX_MEM,
  input  logic [31:0]           ALUResult_EX_MEM,
  input  logic [31:0]           MemWdata_EX_MEM,
  input  logic [31:0]           PC_EX_MEM,
  input  logic [31:0]           HI_EX_MEM,
  input  logic [31:0]           LO_EX_MEM,
  memory_stage_if.master        data_bus,
  output logic                  MEM_stall,
  output logic                  valid_MEM_WB,
  output logic                  MemToReg_MEM_WB,
  output logic [3:0]            RegWrite_MEM_WB,
  output logic [1:0]            MFHL_MEM_WB,
  output logic [4:0]            RegWaddr_MEM_WB,
  output logic [31:0]           ALUResult_MEM_WB,
  output logic [31:0]           PC_MEM_WB,
  output logic [31:0]           MemRdata_MEM_WB,
  output logic [31:0]           HI_MEM_WB,
  output logic [31:0]           LO_MEM_WB
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [2:0] {
    LD_W = 3'b000, LD_B = 3'b001, LD_BU = 3'b010, LD_H = 3'b011,
    LD_HU = 3'b100, LD_WL = 3'b101, LD_WR = 3'b110
  } load_t;

  state_t      state;
  load_t       load_type;
  logic        mem_op;
  logic        mem_done;
  logic        latch_wb;
  logic [1:0]  byte_off;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [3:0]  load_rw;

  assign load_type = load_t'(LoadType_EX_MEM);
  assign byte_off  = ALUResult_EX_MEM[1:0];
  assign mem_op    = valid_EX_MEM & (MemRead_EX_MEM | MemWrite_EX_MEM);
  assign mem_done  = (state == WAIT) & data_bus.data_data_ok;
  assign MEM_stall = mem_op & ~mem_done;
  assign latch_wb  = (valid_EX_MEM & ~mem_op) | mem_done;

  // Request is raised combinationally in IDLE so an immediate addr_ok saves a cycle.
  assign data_bus.data_req = mem_op & ((state == IDLE) | (state == REQ));
  assign data_bus.data_wr  = MemWrite_EX_MEM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (mem_op) state <= data_bus.data_addr_ok ? WAIT : REQ;
        REQ:  if (data_bus.data_addr_ok) state <= WAIT;
        WAIT: if (data_bus.data_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_bus.data_addr = ALUResult_EX_MEM;
    data_bus.data_size = 2'd2;
    if (MemWrite_EX_MEM) begin
      data_bus.data_size = StoreSize_EX_MEM;
    end else begin
      case (load_type)
        LD_B, LD_BU: data_bus.data_size = 2'd0;
        LD_H, LD_HU: data_bus.data_size = 2'd1;
        default:     data_bus.data_size = 2'd2;
      endcase
      if (load_type == LD_WL || load_type == LD_WR)
        data_bus.data_addr[1:0] = '0;
    end
  end

  always_comb begin
    case (StoreSize_EX_MEM)
      2'd0:    data_bus.data_wdata = {4{MemWdata_EX_MEM[7:0]}};
      2'd1:    data_bus.data_wdata = {2{MemWdata_EX_MEM[15:0]}};
      default: data_bus.data_wdata = MemWdata_EX_MEM;
    endcase
  end

  always_comb begin
    rd_byte   = 8'(data_bus.data_rdata >> {byte_off, 3'b000});
    rd_half   = byte_off[1] ? data_bus.data_rdata[31:16] : data_bus.data_rdata[15:0];
    load_data = data_bus.data_rdata;
    load_rw   = RegWrite_EX_MEM;
    case (load_type)
      LD_B:  load_data = {{24{rd_byte[7]}}, rd_byte};
      LD_BU: load_data = {24'd0, rd_byte};
      LD_H:  load_data = {{16{rd_half[15]}}, rd_half};
      LD_HU: load_data = {16'd0, rd_half};
      // ~byte_off == 3 - byte_off for a 2-bit offset
      LD_WL: begin
        load_data = data_bus.data_rdata << {~byte_off, 3'b000};
        load_rw   = 4'b1111 << ~byte_off;
      end
      LD_WR: begin
        load_data = data_bus.data_rdata >> {byte_off, 3'b000};
        load_rw   = 4'b1111 >> byte_off;
      end
      default: load_data = data_bus.data_rdata;
    endcase
    if (!MemRead_EX_MEM)
      load_rw = RegWrite_EX_MEM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_MEM_WB     <= 1'b0;
      MemToReg_MEM_WB  <= 1'b0;
      RegWrite_MEM_WB  <= '0;
      MFHL_MEM_WB      <= '0;
      RegWaddr_MEM_WB  <= '0;
      ALUResult_MEM_WB <= '0;
      PC_MEM_WB        <= RESET_PC;
      MemRdata_MEM_WB  <= '0;
      HI_MEM_WB        <= '0;
      LO_MEM_WB        <= '0;
    end else if (latch_wb) begin
      valid_MEM_WB     <= 1'b1;
      MemToReg_MEM_WB  <= MemToReg_EX_MEM;
      RegWrite_MEM_WB  <= load_rw;
      MFHL_MEM_WB      <= MFHL_EX_MEM;
      RegWaddr_MEM_WB  <= RegWaddr_EX_MEM;
      ALUResult_MEM_WB <= ALUResult_EX_MEM;
      PC_MEM_WB        <= PC_EX_MEM;
      MemRdata_MEM_WB  <= load_data;
      HI_MEM_WB        <= HI_EX_MEM;
      LO_MEM_WB        <= LO_EX_MEM;
    end else begin
      valid_MEM_WB     <= 1'b0;
      MemToReg_MEM_WB  <= 1'b0;
      RegWrite_MEM_WB  <= '0;
      MFHL_MEM_WB      <= '0;
    end
  end

endmodule
